// File: rtl/lcd_parallel_bus_writer_if.sv
`default_nettype none
// ============================================================================
// Module   : lcd_parallel_bus_writer_if
// Brief    : Word stream from the VPU and 8080-style LCD pins of the writer.
// Revision : 1.0
// ============================================================================
interface lcd_parallel_bus_writer_if #(
    parameter int BUS_W = 8
);
    logic             in_valid;
    logic             in_ready;
    logic             in_dc;
    logic [15:0]      in_data;
    logic             in_wide;
    logic             in_last;
    logic             lcd_rst_n;
    logic             lcd_cs_n;
    logic             lcd_rs;
    logic             lcd_wr_n;
    logic             lcd_rd_n;
    logic [BUS_W-1:0] lcd_d;

    modport master (
        output in_valid, in_dc, in_data, in_wide, in_last,
        input  in_ready, lcd_rst_n, lcd_cs_n, lcd_rs, lcd_wr_n, lcd_rd_n, lcd_d
    );

    modport slave (
        input  in_valid, in_dc, in_data, in_wide, in_last,
        output in_ready, lcd_rst_n, lcd_cs_n, lcd_rs, lcd_wr_n, lcd_rd_n, lcd_d
    );
endinterface
`default_nettype wire

// File: rtl/lcd_parallel_bus_writer.sv
`default_nettype none
// ============================================================================
// Module   : lcd_parallel_bus_writer
// Brief    : Write-only 8080 parallel bus master with LCD hardware reset
//            sequencer, 16-bit word splitting and chip-select grouping.
// Revision : 1.0
// ============================================================================
module lcd_parallel_bus_writer #(
    parameter int BUS_W        = 8,
    parameter int WR_LOW_CYC   = 2,
    parameter int WR_HIGH_CYC  = 2,
    parameter int RST_LOW_CYC  = 1000,
    parameter int RST_WAIT_CYC = 12000000
) (
    input  wire logic                      clk,
    input  wire logic                      rst,
    lcd_parallel_bus_writer_if.slave       bus,
    input  wire logic                      init_start,
    output logic                           lcd_ready,
    output logic                           busy
);

    localparam int c_max_a   = (RST_LOW_CYC > RST_WAIT_CYC) ? RST_LOW_CYC : RST_WAIT_CYC;
    localparam int c_max_b   = (WR_LOW_CYC > WR_HIGH_CYC) ? WR_LOW_CYC : WR_HIGH_CYC;
    localparam int c_max_cyc = (c_max_a > c_max_b) ? c_max_a : c_max_b;
    localparam int c_cnt_w   = $clog2(c_max_cyc + 1);

    localparam logic [c_cnt_w-1:0] c_cnt_one  = c_cnt_w'(1);
    localparam logic [c_cnt_w-1:0] c_rst_low  = c_cnt_w'(RST_LOW_CYC);
    localparam logic [c_cnt_w-1:0] c_rst_wait = c_cnt_w'(RST_WAIT_CYC);
    localparam logic [c_cnt_w-1:0] c_wr_low   = c_cnt_w'(WR_LOW_CYC);
    localparam logic [c_cnt_w-1:0] c_wr_high  = c_cnt_w'(WR_HIGH_CYC);

    generate
        if (BUS_W != 8 && BUS_W != 16) begin : g_bad_bus_w
            $error("lcd_parallel_bus_writer: BUS_W must be 8 or 16");
        end
        if (WR_LOW_CYC < 1 || WR_HIGH_CYC < 1 || RST_LOW_CYC < 1 || RST_WAIT_CYC < 1) begin : g_bad_timing
            $error("lcd_parallel_bus_writer: all cycle parameters must be >= 1");
        end
    endgenerate

    typedef enum logic [2:0] {
        ST_RST_LOW  = 3'd0,
        ST_RST_WAIT = 3'd1,
        ST_IDLE     = 3'd2,
        ST_SETUP    = 3'd3,
        ST_WR_LO    = 3'd4,
        ST_WR_HI    = 3'd5
    } state_t;

    state_t               r_state;
    state_t               w_state_nxt;
    logic [c_cnt_w-1:0]   r_cnt;
    logic [c_cnt_w-1:0]   w_cnt_nxt;
    logic [c_cnt_w-1:0]   w_cnt_inc;
    logic                 r_second;
    logic                 w_second_nxt;
    logic                 r_last;
    logic                 w_last_nxt;
    logic [7:0]           r_lo_byte;
    logic [7:0]           w_lo_byte_nxt;

    logic                 r_rst_n;
    logic                 w_rst_n_nxt;
    logic                 r_cs_n;
    logic                 w_cs_n_nxt;
    logic                 r_rs;
    logic                 w_rs_nxt;
    logic                 r_wr_n;
    logic                 w_wr_n_nxt;
    logic                 r_rd_n;
    logic [BUS_W-1:0]     r_d;
    logic [BUS_W-1:0]     w_d_nxt;
    logic                 r_in_ready;
    logic                 r_lcd_ready;
    logic                 r_busy;

    logic [BUS_W-1:0]     w_first_beat;
    logic [BUS_W-1:0]     w_second_beat;
    logic                 w_two_beat;
    logic                 w_fire;

    // On the 8-bit bus a wide word goes out high byte first; the low byte is
    // parked in r_lo_byte for the second beat.
    generate
        if (BUS_W == 16) begin : g_bus16
            assign w_first_beat  = bus.in_data;
            assign w_second_beat = {8'h00, r_lo_byte};
            assign w_two_beat    = 1'b0;
        end else begin : g_bus8
            assign w_first_beat  = bus.in_wide ? bus.in_data[15:8] : bus.in_data[7:0];
            assign w_second_beat = r_lo_byte;
            assign w_two_beat    = bus.in_wide;
        end
    endgenerate

    assign w_fire    = bus.in_valid & r_in_ready;
    assign w_cnt_inc = r_cnt + c_cnt_one;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= ST_RST_LOW;
            r_cnt       <= '0;
            r_second    <= 1'b0;
            r_last      <= 1'b0;
            r_lo_byte   <= 8'h00;
            r_rst_n     <= 1'b0;
            r_cs_n      <= 1'b1;
            r_rs        <= 1'b0;
            r_wr_n      <= 1'b1;
            r_rd_n      <= 1'b1;
            r_d         <= '0;
            r_in_ready  <= 1'b0;
            r_lcd_ready <= 1'b0;
            r_busy      <= 1'b1;
        end else begin
            r_state     <= w_state_nxt;
            r_cnt       <= w_cnt_nxt;
            r_second    <= w_second_nxt;
            r_last      <= w_last_nxt;
            r_lo_byte   <= w_lo_byte_nxt;
            r_rst_n     <= w_rst_n_nxt;
            r_cs_n      <= w_cs_n_nxt;
            r_rs        <= w_rs_nxt;
            r_wr_n      <= w_wr_n_nxt;
            r_rd_n      <= 1'b1;
            r_d         <= w_d_nxt;
            r_in_ready  <= (w_state_nxt == ST_IDLE);
            r_lcd_ready <= (w_state_nxt == ST_IDLE);
            r_busy      <= (w_state_nxt != ST_IDLE);
        end
    end

    // Phase counters start at 1 on entry and the phase ends when the count
    // reaches its length. The reset cycle itself leaves r_cnt at 0, so the
    // first RST_LOW after rst includes the cycle in which rst was sampled.
    always_comb begin
        w_state_nxt   = r_state;
        w_cnt_nxt     = r_cnt;
        w_second_nxt  = r_second;
        w_last_nxt    = r_last;
        w_lo_byte_nxt = r_lo_byte;
        w_rst_n_nxt   = r_rst_n;
        w_cs_n_nxt    = r_cs_n;
        w_rs_nxt      = r_rs;
        w_wr_n_nxt    = 1'b1;
        w_d_nxt       = r_d;

        case (r_state)
            ST_RST_LOW: begin
                w_cs_n_nxt = 1'b1;
                if (r_cnt == c_rst_low) begin
                    w_state_nxt = ST_RST_WAIT;
                    w_cnt_nxt   = c_cnt_one;
                    w_rst_n_nxt = 1'b1;
                end else begin
                    w_cnt_nxt   = w_cnt_inc;
                    w_rst_n_nxt = 1'b0;
                end
            end
            ST_RST_WAIT: begin
                if (r_cnt == c_rst_wait) begin
                    w_state_nxt = ST_IDLE;
                end else begin
                    w_cnt_nxt   = w_cnt_inc;
                end
            end
            ST_IDLE: begin
                if (w_fire) begin
                    w_state_nxt   = ST_SETUP;
                    w_cs_n_nxt    = 1'b0;
                    w_rs_nxt      = bus.in_dc;
                    w_d_nxt       = w_first_beat;
                    w_last_nxt    = bus.in_last;
                    w_second_nxt  = w_two_beat;
                    w_lo_byte_nxt = bus.in_data[7:0];
                end else if (init_start) begin
                    w_state_nxt = ST_RST_LOW;
                    w_cnt_nxt   = c_cnt_one;
                    w_rst_n_nxt = 1'b0;
                    w_cs_n_nxt  = 1'b1;
                end
            end
            ST_SETUP: begin
                w_state_nxt = ST_WR_LO;
                w_cnt_nxt   = c_cnt_one;
                w_wr_n_nxt  = 1'b0;
            end
            ST_WR_LO: begin
                if (r_cnt == c_wr_low) begin
                    w_state_nxt = ST_WR_HI;
                    w_cnt_nxt   = c_cnt_one;
                end else begin
                    w_cnt_nxt   = w_cnt_inc;
                    w_wr_n_nxt  = 1'b0;
                end
            end
            ST_WR_HI: begin
                if (r_cnt != c_wr_high) begin
                    w_cnt_nxt = w_cnt_inc;
                end else if (r_second) begin
                    w_state_nxt  = ST_SETUP;
                    w_second_nxt = 1'b0;
                    w_d_nxt      = w_second_beat;
                end else begin
                    w_state_nxt  = ST_IDLE;
                    w_cs_n_nxt   = r_last;
                end
            end
            default: begin
                w_state_nxt = ST_RST_LOW;
                w_cnt_nxt   = c_cnt_one;
                w_rst_n_nxt = 1'b0;
                w_cs_n_nxt  = 1'b1;
            end
        endcase
    end

    assign bus.in_ready  = r_in_ready;
    assign bus.lcd_rst_n = r_rst_n;
    assign bus.lcd_cs_n  = r_cs_n;
    assign bus.lcd_rs    = r_rs;
    assign bus.lcd_wr_n  = r_wr_n;
    assign bus.lcd_rd_n  = r_rd_n;
    assign bus.lcd_d     = r_d;
    assign lcd_ready     = r_lcd_ready;
    assign busy          = r_busy;

endmodule
`default_nettype wire

// File: tb/tb_lcd_parallel_bus_writer.sv
`default_nettype none
// ============================================================================
// Module   : tb_lcd_parallel_bus_writer
// Brief    : Directed scoreboard bench for the 8- and 16-bit writer variants.
// Revision : 1.0
// ============================================================================
module tb_lcd_parallel_bus_writer;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic init8 = 1'b0;
    logic init16 = 1'b0;
    logic ready8, busy8, ready16, busy16;

    int n_checks = 0;
    int n_fail   = 0;

    logic [16:0] q8[$];
    logic [16:0] q16[$];
    logic prev_wr8  = 1'b1;
    logic prev_wr16 = 1'b1;

    lcd_parallel_bus_writer_if #(.BUS_W(8))  bus8();
    lcd_parallel_bus_writer_if #(.BUS_W(16)) bus16();

    always #5 clk = ~clk;

    lcd_parallel_bus_writer #(
        .BUS_W(8), .WR_LOW_CYC(2), .WR_HIGH_CYC(2), .RST_LOW_CYC(4), .RST_WAIT_CYC(10)
    ) dut8 (
        .clk(clk), .rst(rst), .bus(bus8), .init_start(init8),
        .lcd_ready(ready8), .busy(busy8)
    );

    lcd_parallel_bus_writer #(
        .BUS_W(16), .WR_LOW_CYC(2), .WR_HIGH_CYC(2), .RST_LOW_CYC(4), .RST_WAIT_CYC(10)
    ) dut16 (
        .clk(clk), .rst(rst), .bus(bus16), .init_start(init16),
        .lcd_ready(ready16), .busy(busy16)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Scoreboard: every wr_n rising edge is one latched beat {rs, data}.
    always @(negedge clk) begin
        if (!rst && prev_wr8 === 1'b0 && bus8.lcd_wr_n === 1'b1) begin
            if (q8.size() == 0) begin
                check("beat8_unexpected", {15'd0, bus8.lcd_rs, 8'h00, bus8.lcd_d}, 32'hDEAD);
            end else begin
                check("beat8", {15'd0, bus8.lcd_rs, 8'h00, bus8.lcd_d}, {15'd0, q8.pop_front()});
                check("beat8_cs", {31'd0, bus8.lcd_cs_n}, 32'd0);
            end
        end
        prev_wr8 = bus8.lcd_wr_n;
    end

    always @(negedge clk) begin
        if (!rst && prev_wr16 === 1'b0 && bus16.lcd_wr_n === 1'b1) begin
            if (q16.size() == 0) begin
                check("beat16_unexpected", {15'd0, bus16.lcd_rs, bus16.lcd_d}, 32'hDEAD);
            end else begin
                check("beat16", {15'd0, bus16.lcd_rs, bus16.lcd_d}, {15'd0, q16.pop_front()});
                check("beat16_cs", {31'd0, bus16.lcd_cs_n}, 32'd0);
            end
        end
        prev_wr16 = bus16.lcd_wr_n;
    end

    // Called on a negedge; returns on the negedge of the SETUP cycle with the
    // inputs scrambled so that only the captured word can reach the bus.
    task automatic send8(input logic dc, input logic [15:0] data, input logic wide, input logic last);
        bus8.in_valid = 1'b1;
        bus8.in_dc    = dc;
        bus8.in_data  = data;
        bus8.in_wide  = wide;
        bus8.in_last  = last;
        for (int i = 0; i < 200; i++) begin
            if (bus8.in_ready === 1'b1) begin
                @(negedge clk);
                bus8.in_valid = 1'b0;
                bus8.in_dc    = ~dc;
                bus8.in_data  = ~data;
                bus8.in_wide  = ~wide;
                bus8.in_last  = ~last;
                return;
            end
            @(negedge clk);
        end
        check("send8_timeout", 32'd0, 32'd1);
        bus8.in_valid = 1'b0;
    endtask

    task automatic send16(input logic dc, input logic [15:0] data, input logic wide, input logic last);
        bus16.in_valid = 1'b1;
        bus16.in_dc    = dc;
        bus16.in_data  = data;
        bus16.in_wide  = wide;
        bus16.in_last  = last;
        for (int i = 0; i < 200; i++) begin
            if (bus16.in_ready === 1'b1) begin
                @(negedge clk);
                bus16.in_valid = 1'b0;
                bus16.in_dc    = ~dc;
                bus16.in_data  = ~data;
                bus16.in_wide  = ~wide;
                bus16.in_last  = ~last;
                return;
            end
            @(negedge clk);
        end
        check("send16_timeout", 32'd0, 32'd1);
        bus16.in_valid = 1'b0;
    endtask

    task automatic drain(input string tag);
        for (int i = 0; i < 100; i++) begin
            if (q8.size() == 0 && q16.size() == 0) break;
            @(negedge clk);
        end
        check(tag, q8.size() + q16.size(), 32'd0);
    endtask

    task automatic wait_ready(input string tag);
        for (int i = 0; i < 200; i++) begin
            if (ready8 === 1'b1 && ready16 === 1'b1) break;
            @(negedge clk);
        end
        check(tag, {30'd0, ready8, ready16}, 32'd3);
    endtask

    initial begin
        int n_low;
        int n_rst_low;
        logic rstn_seen_low;

        bus8.in_valid  = 1'b0; bus8.in_dc  = 1'b0; bus8.in_data  = 16'h0; bus8.in_wide  = 1'b0; bus8.in_last  = 1'b0;
        bus16.in_valid = 1'b0; bus16.in_dc = 1'b0; bus16.in_data = 16'h0; bus16.in_wide = 1'b0; bus16.in_last = 1'b0;

        repeat (3) @(posedge clk);
        @(negedge clk);
        // {rst_n, cs_n, rs, wr_n, rd_n, in_ready, lcd_ready, busy}
        check("reset_ctrl8", {24'd0, bus8.lcd_rst_n, bus8.lcd_cs_n, bus8.lcd_rs, bus8.lcd_wr_n,
                              bus8.lcd_rd_n, bus8.in_ready, ready8, busy8}, 32'b0101_1001);
        check("reset_d8", {24'd0, bus8.lcd_d}, 32'd0);
        check("reset_d16", {16'd0, bus16.lcd_d}, 32'd0);

        // Cycle k after release: rst_n low for k=1..4, lcd_ready from k=15.
        rst = 1'b0;
        for (int k = 1; k <= 16; k++) begin
            @(negedge clk);
            check($sformatf("rstseq_c%0d", k),
                  {29'd0, bus8.lcd_rst_n, ready8, bus8.lcd_cs_n},
                  {29'd0, (k > 4), (k >= 15), 1'b1});
        end
        check("rstseq_ready16", {31'd0, ready16}, 32'd1);

        // Single command byte.
        q8.push_back({1'b0, 16'h002C});
        send8(1'b0, 16'h002C, 1'b0, 1'b1);
        check("cmd_rs_d", {23'd0, bus8.lcd_rs, bus8.lcd_d}, {23'd0, 1'b0, 8'h2C});
        for (int c = 0; c <= 5; c++) begin
            if (c > 0) @(negedge clk);
            check($sformatf("cmd_cs_wr_c%0d", c), {30'd0, bus8.lcd_cs_n, bus8.lcd_wr_n},
                  {30'd0, (c == 5), !(c == 1 || c == 2)});
        end
        drain("cmd_drain");

        // Two wide pixels chained under one chip select.
        q8.push_back({1'b1, 16'h00F8});
        q8.push_back({1'b1, 16'h001F});
        send8(1'b1, 16'hF81F, 1'b1, 1'b0);
        q8.push_back({1'b1, 16'h0007});
        q8.push_back({1'b1, 16'h00E0});
        bus8.in_valid = 1'b1; bus8.in_dc = 1'b1; bus8.in_data = 16'h07E0;
        bus8.in_wide  = 1'b1; bus8.in_last = 1'b1;
        for (int c = 1; c <= 22; c++) begin
            if (c > 1) @(negedge clk);
            if (c == 12) begin
                bus8.in_valid = 1'b0; bus8.in_data = 16'hFFFF; bus8.in_dc = 1'b0;
            end
            check($sformatf("pix_cs_rdy_c%0d", c), {30'd0, bus8.lcd_cs_n, bus8.in_ready},
                  {30'd0, (c == 22), (c == 11 || c == 22)});
        end
        drain("pix_drain");

        // rst mid WR_LO of a two-beat word: no beat may be emitted.
        send8(1'b1, 16'hABCD, 1'b1, 1'b1);
        @(negedge clk);
        check("midrst_wrlo", {31'd0, bus8.lcd_wr_n}, 32'd0);
        rst = 1'b1;
        @(negedge clk);
        check("midrst_vals", {24'd0, bus8.lcd_rst_n, bus8.lcd_cs_n, bus8.lcd_rs, bus8.lcd_wr_n,
                              bus8.lcd_rd_n, bus8.in_ready, ready8, busy8}, 32'b0101_1001);
        @(negedge clk);
        rst = 1'b0;
        wait_ready("midrst_ready");
        check("midrst_no_beat", q8.size(), 32'd0);

        // init_start alone re-runs the reset sequence.
        init8 = 1'b1;
        @(negedge clk);
        init8 = 1'b0;
        check("init_cs", {30'd0, bus8.lcd_cs_n, bus8.lcd_rst_n}, 32'b10);
        n_low = 0;
        n_rst_low = 0;
        for (int i = 0; i < 100; i++) begin
            if (ready8 === 1'b1) break;
            n_low++;
            if (bus8.lcd_rst_n === 1'b0) n_rst_low++;
            @(negedge clk);
        end
        check("init_ready_low", n_low, 32'd14);
        check("init_rstn_low", n_rst_low, 32'd4);

        // init_start with a handshake: the word wins.
        init8 = 1'b1;
        q8.push_back({1'b1, 16'h0055});
        send8(1'b1, 16'h0055, 1'b0, 1'b1);
        init8 = 1'b0;
        rstn_seen_low = 1'b0;
        for (int i = 0; i < 8; i++) begin
            if (bus8.lcd_rst_n !== 1'b1) rstn_seen_low = 1'b1;
            @(negedge clk);
        end
        check("init_hs_no_reset", {31'd0, rstn_seen_low}, 32'd0);
        drain("init_hs_drain");
        check("init_hs_ready", {31'd0, ready8}, 32'd1);

        // 16-bit bus: one beat per word regardless of in_wide.
        q16.push_back({1'b1, 16'h1234});
        send16(1'b1, 16'h1234, 1'b1, 1'b1);
        check("w16_d", {16'd0, bus16.lcd_d}, 32'h1234);
        q16.push_back({1'b0, 16'h00AB});
        send16(1'b0, 16'h00AB, 1'b0, 1'b1);
        drain("w16_drain");
        repeat (2) @(negedge clk);
        check("w16_idle", {30'd0, bus16.lcd_cs_n, bus16.in_ready}, 32'b11);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
